// File: rtl/dac_serial_tx_pkg.sv
// Shared definitions for the serial DAC transmitter.
//  - Input fixed-point sample format (sign / fractional / integer magnitude bits).
//  - DAC frame layout: LEAD_ZEROS zero bits followed by a DATA_BITS offset-binary code.
//  - FSM state encoding used by dac_serial_tx.
package dac_serial_tx_pkg;

  // Input sample format: two's complement, PF fractional bits.
  localparam int unsigned SIGN = 1;
  localparam int unsigned PF   = 14;
  localparam int unsigned MAG  = 7;
  localparam int unsigned SIZE = SIGN + PF + MAG;

  // DAC frame: 2 don't-care bits + 2 mode bits (00 = normal), then the code.
  localparam int unsigned DATA_BITS  = 12;
  localparam int unsigned LEAD_ZEROS = 4;
  localparam int unsigned FW         = LEAD_ZEROS + DATA_BITS;

  // Offset-binary mid-scale and full-scale code values.
  localparam int unsigned MID_SCALE = 2 ** (DATA_BITS - 1);
  localparam int unsigned CODE_MAX  = (2 ** DATA_BITS) - 1;

  // Right shift that aligns the input's binary point to a DATA_BITS signed code.
  localparam int unsigned SHIFT_AMT = PF - (DATA_BITS - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StQuiet = 2'd2
  } state_e;

  // Prepend the leading zero (don't-care + mode) bits to a DAC code.
  function automatic logic [FW-1:0] build_frame(input logic [DATA_BITS-1:0] code);
    return {{LEAD_ZEROS{1'b0}}, code};
  endfunction

endpackage

// File: rtl/dac_code_sat.sv
// Combinational conversion of a signed fixed-point sample to an offset-binary DAC code.
//  dato  in   SIZE       signed sample, PF fractional bits
//  code  out  DATA_BITS  offset-binary code, clipped to [0, 2^DATA_BITS-1]
//  sat   out  1          the sample was outside the DAC range and got clipped
module dac_code_sat
  import dac_serial_tx_pkg::*;
(
  input  logic [SIZE-1:0]      dato,
  output logic [DATA_BITS-1:0] code,
  output logic                 sat
);

  // One extra bit of headroom so the mid-scale offset can never wrap.
  logic [SIZE:0] shifted;
  logic [SIZE:0] offset;

  always_comb begin
    shifted = $unsigned($signed({dato[SIZE-1], dato}) >>> SHIFT_AMT);
    offset  = shifted + (SIZE + 1)'(MID_SCALE);
    code    = '0;
    sat     = 1'b0;
    if (offset[SIZE]) begin
      // Below negative full scale.
      code = '0;
      sat  = 1'b1;
    end else if (offset > (SIZE + 1)'(CODE_MAX)) begin
      // Above positive full scale.
      code = '1;
      sat  = 1'b1;
    end else begin
      code = offset[DATA_BITS-1:0];
    end
  end

endmodule

// File: rtl/dac_serial_tx.sv
// Serial transmitter for a DAC121S101-style DAC (16-bit frame, active-low SYNC).
// Accepts one signed fixed-point sample, converts it to a saturated offset-binary code and
// shifts {LEAD_ZEROS zeros, code} out MSB first. Every output is a flop.
//  clk      in   1     system clock, rising edge
//  rst      in   1     asynchronous active-low reset
//  start    in   1     send dato_in; only looked at while idle
//  dato_in  in   SIZE  signed sample, PF fractional bits
//  sclk     out  1     serial clock, idles high; DAC samples sdo on the falling edge
//  cs       out  1     frame sync, active low
//  sdo      out  1     serial data, MSB first
//  busy     out  1     frame in progress (shift or quiet time)
//  done     out  1     one-cycle pulse at end of frame
//  sat      out  1     last accepted sample was clipped, held until next accept
module dac_serial_tx
  import dac_serial_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] dato_in,
  output logic            sclk,
  output logic            cs,
  output logic            sdo,
  output logic            busy,
  output logic            done,
  output logic            sat
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(FW);

  localparam logic [CntW-1:0] CntLast  = CntW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitFirst = BitW'(FW - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;      // cycles within the current sclk half-period
  logic [BitW-1:0] bit_q, bit_d;      // index of the bit currently on sdo
  logic [FW-1:0]   shreg_q, shreg_d;  // MSB is the next bit to drive
  logic            sclk_q, sclk_d;
  logic            cs_q, cs_d;
  logic            sdo_q, sdo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sat_q, sat_d;

  logic [DATA_BITS-1:0] conv_code;
  logic                 conv_sat;
  logic [FW-1:0]        frame;

  dac_code_sat u_code_sat (
    .dato (dato_in),
    .code (conv_code),
    .sat  (conv_sat)
  );

  assign frame = build_frame(conv_code);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    sdo_d   = sdo_q;
    busy_d  = busy_q;
    sat_d   = sat_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // The first bit goes out together with cs falling; the rest wait in shreg.
          state_d = StShift;
          cnt_d   = '0;
          bit_d   = BitFirst;
          shreg_d = {frame[FW-2:0], 1'b0};
          sdo_d   = frame[FW-1];
          sclk_d  = 1'b1;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          sat_d   = conv_sat;
        end
      end

      StShift: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (sclk_q) begin
            // End of high phase: falling edge, DAC samples sdo here.
            sclk_d = 1'b0;
          end else if (bit_q == '0) begin
            // Last bit's low phase is over: release the DAC for its quiet time.
            state_d = StQuiet;
            sclk_d  = 1'b1;
            cs_d    = 1'b1;
            sdo_d   = 1'b0;
          end else begin
            // Rising edge: present the next bit.
            bit_d   = bit_q - 1'b1;
            sclk_d  = 1'b1;
            sdo_d   = shreg_q[FW-1];
            shreg_d = {shreg_q[FW-2:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StQuiet: begin
        if (cnt_q == CntLast) begin
          // done and busy fall together, so a start in the done cycle is taken.
          state_d = StIdle;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b1;
      cs_q    <= 1'b1;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

  assign sclk = sclk_q;
  assign cs   = cs_q;
  assign sdo  = sdo_q;
  assign busy = busy_q;
  assign done = done_q;
  assign sat  = sat_q;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Bench for dac_serial_tx: one instance with CLK_DIV=4 and one with CLK_DIV=1.
// Stimulus pushes the expected frame/sat into a queue; a monitor per instance rebuilds the frame
// from sdo at each sclk falling edge and compares when done pulses.
`timescale 1ns/1ps
module tb_dac_serial_tx;
  import dac_serial_tx_pkg::*;

  localparam int unsigned DIV0 = 4;
  localparam int unsigned DIV1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            start0, start1;
  logic [SIZE-1:0] dato0, dato1;
  logic            sclk0, cs0, sdo0, busy0, done0, sat0;
  logic            sclk1, cs1, sdo1, busy1, done1, sat1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [FW-1:0] frame;
    logic          sat;
  } exp_t;

  exp_t exp0_q[$];
  exp_t exp1_q[$];

  dac_serial_tx #(.CLK_DIV(DIV0)) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .start   (start0),
    .dato_in (dato0),
    .sclk    (sclk0),
    .cs      (cs0),
    .sdo     (sdo0),
    .busy    (busy0),
    .done    (done0),
    .sat     (sat0)
  );

  dac_serial_tx #(.CLK_DIV(DIV1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .start   (start1),
    .dato_in (dato1),
    .sclk    (sclk1),
    .cs      (cs1),
    .sdo     (sdo1),
    .busy    (busy1),
    .done    (done1),
    .sat     (sat1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Rebuilds frames from one instance's serial outputs and scores them at done.
  task automatic monitor(input bit id);
    logic          prev;
    logic [FW-1:0] bits;
    int            n;
    exp_t          e;
    logic          s, c, d, dn, st;
    prev = 1'b1;
    bits = '0;
    n    = 0;
    forever begin
      @(negedge clk);
      s  = id ? sclk1 : sclk0;
      c  = id ? cs1   : cs0;
      d  = id ? sdo1  : sdo0;
      dn = id ? done1 : done0;
      st = id ? sat1  : sat0;
      if (!rst) begin
        n    = 0;
        prev = 1'b1;
      end else begin
        if (prev && !s && !c) begin
          bits = {bits[FW-2:0], d};
          n++;
        end
        prev = s;
        if (dn) begin
          if ((id ? exp1_q.size() : exp0_q.size()) == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame dut%0d: got frame 0x%0h, want none", id, bits);
          end else begin
            e = id ? exp1_q.pop_front() : exp0_q.pop_front();
            check($sformatf("frame dut%0d", id), 32'(bits), 32'(e.frame));
            check($sformatf("sat dut%0d", id), 32'(st), 32'(e.sat));
            check($sformatf("bit_count dut%0d", id), n, FW);
          end
          n = 0;
        end
      end
    end
  endtask

  initial monitor(1'b0);
  initial monitor(1'b1);

  // Start one frame on dut0 from an idle state and check its timing.
  task automatic run_frame(input logic [SIZE-1:0] d, input logic [FW-1:0] f, input logic s);
    int lat;
    int cs_low;
    bit seen;
    lat    = 0;
    cs_low = 0;
    seen   = 1'b0;
    exp0_q.push_back(exp_t'{frame: f, sat: s});
    dato0  = d;
    start0 = 1'b1;
    while (!seen && lat < 1000) begin
      step();
      lat++;
      if (lat == 1) begin
        start0 = 1'b0;
        dato0  = ~d;  // must not leak into the latched frame
      end
      if (!cs0) cs_low++;
      if (done0) seen = 1'b1;
    end
    check("latency", lat, FW * 2 * DIV0 + DIV0 + 1);
    check("cs_low_cycles", cs_low, FW * 2 * DIV0);
    check("busy_at_done", 32'(busy0), 0);
    step();
    check("done_width", 32'(done0), 0);
  endtask

  task automatic wait_done0(input int limit);
    int cycles;
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!done0 && cycles < limit);
    check("done_seen", 32'(done0), 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int gap;
    int busy_cnt;
    int lat;
    int cs_low;

    rst    = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    dato0  = '0;
    dato1  = '0;
    repeat (3) step();

    check("reset_sclk", 32'(sclk0), 1);
    check("reset_cs", 32'(cs0), 1);
    check("reset_sdo", 32'(sdo0), 0);
    check("reset_busy", 32'(busy0), 0);
    check("reset_done", 32'(done0), 0);
    check("reset_sat", 32'(sat0), 0);

    rst = 1'b1;
    step();

    run_frame(22'h000000, 16'h0800, 1'b0);  // zero -> mid-scale
    run_frame(22'h002000, 16'h0C00, 1'b0);  // +0.5
    run_frame(22'h3FC000, 16'h0000, 1'b0);  // -1.0, exactly full scale
    run_frame(22'h004000, 16'h0FFF, 1'b1);  // +1.0 clips high
    run_frame(22'h200000, 16'h0000, 1'b1);  // most negative clips low

    // Start pulsed during bit 7 must be dropped.
    exp0_q.push_back(exp_t'{frame: 16'h0800, sat: 1'b0});
    dato0  = 22'h000000;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (8 * 2 * DIV0) step();
    start0 = 1'b1;
    dato0  = 22'h004000;
    step();
    start0 = 1'b0;
    check("busy_mid_frame", 32'(busy0), 1);
    wait_done0(1000);
    busy_cnt = 0;
    repeat (300) begin
      step();
      if (busy0) busy_cnt++;
    end
    check("ignored_start_busy", busy_cnt, 0);
    check("ignored_start_sat", 32'(sat0), 0);

    // Start held high: two frames back to back.
    exp0_q.push_back(exp_t'{frame: 16'h0C00, sat: 1'b0});
    exp0_q.push_back(exp_t'{frame: 16'h0C00, sat: 1'b0});
    dato0  = 22'h002000;
    start0 = 1'b1;
    n = 0;
    while (cs0 && n < 100) begin step(); n++; end
    n = 0;
    while (!cs0 && n < 300) begin step(); n++; end
    gap = 0;
    while (cs0 && gap < 100) begin gap++; step(); end
    start0 = 1'b0;
    check("b2b_cs_gap", gap, DIV0 + 1);
    check("b2b_second_busy", 32'(busy0), 1);
    wait_done0(1000);
    step();

    // Reset during bit 9 aborts the frame at once.
    dato0  = 22'h002000;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (6 * 2 * DIV0 + 2) step();
    #2 rst = 1'b0;
    #1;
    check("abort_cs", 32'(cs0), 1);
    check("abort_sclk", 32'(sclk0), 1);
    check("abort_busy", 32'(busy0), 0);
    check("abort_sdo", 32'(sdo0), 0);
    step();
    rst = 1'b1;
    step();
    run_frame(22'h3FE000, 16'h0400, 1'b0);  // -0.5 after recovery

    // CLK_DIV=1 instance.
    exp1_q.push_back(exp_t'{frame: 16'h0C00, sat: 1'b0});
    dato1  = 22'h002000;
    start1 = 1'b1;
    lat    = 0;
    cs_low = 0;
    while (lat < 200) begin
      step();
      lat++;
      if (lat == 1) start1 = 1'b0;
      if (!cs1) cs_low++;
      if (done1) break;
    end
    check("div1_latency", lat, FW * 2 * DIV1 + DIV1 + 1);
    check("div1_cs_low", cs_low, FW * 2 * DIV1);

    repeat (4) step();
    check("exp0_drained", exp0_q.size(), 0);
    check("exp1_drained", exp1_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
